// File: rtl/mem_pkg.sv
// Shared types and defaults for the main-memory responder: FSM state encoding,
// default geometry/latency and the MRW read/write encoding.
package mem_pkg;

    localparam int MEM_AW          = 10;
    localparam int MEM_DW          = 32;
    localparam int MEM_WAIT_CYCLES = 4;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with write enable and a registered read port.
// The read register is cleared by reset; the array contents are not.
module mem_array
    import mem_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    // Read register only updates when a read commits, so it holds across writes.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Read data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= {DW{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/main_memory_responder.sv
// Memory-side responder for the cache strobe interface: fixed-latency access, one MReady pulse.
// Optional sticky protocol-error output MErr is enabled with `define MEM_ERR_CHECK_EN.
module main_memory_responder
    import mem_pkg::*;
#(
    parameter int AW          = MEM_AW,
    parameter int DW          = MEM_DW,
    parameter int WAIT_CYCLES = MEM_WAIT_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MStrobe,
    input  logic          MRW,
    input  logic [AW-1:0] MAddr,
    input  logic [DW-1:0] MDataIn,
    output logic [DW-1:0] MDataOut,
    output logic          MReady,
    output logic          MBusy
`ifdef MEM_ERR_CHECK_EN
    ,
    output logic          MErr
`endif
);

    localparam logic [7:0] WAIT_LOAD    = 8'(WAIT_CYCLES - 1);
    localparam bit         SINGLE_CYCLE = (WAIT_CYCLES == 1);

    mem_state_e    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          rw_q, rw_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          held_q, held_d;

    logic          accept_s;
    logic          commit_s;
    logic          cmt_rw_s;
    logic [AW-1:0] ram_addr_s;
    logic [DW-1:0] ram_wdata_s;
    logic          ram_we_s;
    logic          ram_re_s;

    // Next-state, counter and request-register logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        commit_s = 1'b0;
        // A strobe still held from an earlier acceptance is not a new request.
        accept_s = (state_q == IDLE) && MStrobe && !held_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    rw_d    = MRW;
                    addr_d  = MAddr;
                    wdata_d = MDataIn;
                    cnt_d   = WAIT_LOAD;
                    if (SINGLE_CYCLE) begin
                        state_d  = DONE;
                        commit_s = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q <= 8'd1) begin
                    cnt_d    = 8'd0;
                    state_d  = DONE;
                    commit_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        held_d  = MStrobe & (accept_s | held_q);
        ready_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    // Commit path: with a one-cycle latency the request registers load on the
    // same edge as the commit, so the RAM must take the live inputs instead.
    always_comb begin
        if (state_q == IDLE) begin
            cmt_rw_s    = MRW;
            ram_addr_s  = MAddr;
            ram_wdata_s = MDataIn;
        end else begin
            cmt_rw_s    = rw_q;
            ram_addr_s  = addr_q;
            ram_wdata_s = wdata_q;
        end
        ram_we_s = commit_s && !reset && (cmt_rw_s == MEM_WRITE);
        ram_re_s = commit_s && !reset && (cmt_rw_s == MEM_READ);
    end

    // FSM state, counter, request registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            rw_q    <= 1'b0;
            addr_q  <= {AW{1'b0}};
            wdata_q <= {DW{1'b0}};
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            held_q  <= held_d;
        end
    end

    mem_array #(
        .AW(AW),
        .DW(DW)
    ) u_mem_array (
        .clk  (clk),
        .reset(reset),
        .we   (ram_we_s),
        .re   (ram_re_s),
        .addr (ram_addr_s),
        .wdata(ram_wdata_s),
        .rdata(MDataOut)
    );

    assign MReady = ready_q;
    assign MBusy  = busy_q;

`ifdef MEM_ERR_CHECK_EN
    logic err_q, err_d;

    // Sticky error on a fresh strobe arriving while an access is in flight.
    always_comb begin
        err_d = err_q | (MStrobe & busy_q & ~held_q);
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign MErr = err_q;
`endif

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: a WAIT_CYCLES=4 and a WAIT_CYCLES=1 instance
// share one stimulus stream and are checked every cycle against an edge-count model.
module tb_main_memory_responder;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        strobe = 1'b0;
    logic        rw = 1'b0;
    logic [9:0]  addr = 10'd0;
    logic [31:0] wdata = 32'd0;

    logic [1:0]       ready, busy, err;
    logic [1:0][31:0] dout;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    main_memory_responder #(.WAIT_CYCLES(4)) u4 (
        .clk(clk), .reset(reset), .MStrobe(strobe), .MRW(rw), .MAddr(addr),
        .MDataIn(wdata), .MDataOut(dout[0]), .MReady(ready[0]), .MBusy(busy[0])
`ifdef MEM_ERR_CHECK_EN
        , .MErr(err[0])
`endif
    );

    main_memory_responder #(.WAIT_CYCLES(1)) u1 (
        .clk(clk), .reset(reset), .MStrobe(strobe), .MRW(rw), .MAddr(addr),
        .MDataIn(wdata), .MDataOut(dout[1]), .MReady(ready[1]), .MBusy(busy[1])
`ifdef MEM_ERR_CHECK_EN
        , .MErr(err[1])
`endif
    );

`ifndef MEM_ERR_CHECK_EN
    assign err = 2'b00;
`endif

    function automatic int wc(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s [wait=%0d] t=%0t got %h expected %h", name, wc(i), $time, act, exp);
        end
    endtask

    // Reference model: each access is described by the edge index a at which it
    // was accepted; everything else follows from arithmetic on edge numbers.
    int          n = 0;
    int          a_m [2];
    bit          has_m [2];
    bit          held_m [2];
    logic        rw_m [2];
    logic [3:0]  ad_m [2];
    logic [31:0] wd_m [2];
    logic [31:0] mem_m [2][16];
    bit          exp_ready [2];
    bit          exp_busy [2];
    bit          exp_err [2];
    logic [31:0] exp_dout [2];

    always @(posedge clk) begin
        n++;
        for (int i = 0; i < 2; i++) begin
            int p;
            bit busy_before, acc;
            p = wc(i);
            if (reset) begin
                has_m[i] = 1'b0; held_m[i] = 1'b0; exp_ready[i] = 1'b0;
                exp_busy[i] = 1'b0; exp_err[i] = 1'b0; exp_dout[i] = 32'd0;
            end else begin
                busy_before = has_m[i] && (n >= a_m[i] + 1) && (n <= a_m[i] + p);
                if (strobe && busy_before && !held_m[i]) exp_err[i] = 1'b1;
                acc = strobe && !held_m[i] && !busy_before;
                held_m[i] = strobe && (acc || held_m[i]);
                if (acc) begin
                    has_m[i] = 1'b1; a_m[i] = n;
                    rw_m[i] = rw; ad_m[i] = addr[3:0]; wd_m[i] = wdata;
                end
                exp_ready[i] = has_m[i] && (n == a_m[i] + p - 1);
                exp_busy[i]  = has_m[i] && (n >= a_m[i]) && (n <= a_m[i] + p - 1);
                if (exp_ready[i]) begin
                    if (rw_m[i] == MEM_WRITE) mem_m[i][ad_m[i]] = wd_m[i];
                    else exp_dout[i] = mem_m[i][ad_m[i]];
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 2; i++) begin
                check("ready", i, 32'(ready[i]), 32'(exp_ready[i]));
                check("busy", i, 32'(busy[i]), 32'(exp_busy[i]));
                check("dout", i, dout[i], exp_dout[i]);
`ifdef MEM_ERR_CHECK_EN
                check("err", i, 32'(err[i]), 32'(exp_err[i]));
`endif
            end
        end
    end

    task automatic set_req(input logic r, input logic [9:0] ad, input logic [31:0] d);
        strobe = 1'b1; rw = r; addr = ad; wdata = d;
    endtask

    task automatic idle_cycles(input int k);
        strobe = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    initial begin
        int pulses;
        @(posedge clk);
        @(negedge clk);
        check_en = 1'b1;
        check("rst_ready", 0, 32'(ready[0]), 32'd0);
        check("rst_busy", 0, 32'(busy[0]), 32'd0);
        check("rst_dout", 0, dout[0], 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Known contents for every address the bench uses.
        for (int k = 0; k < 16; k++) begin
            set_req(MEM_WRITE, 10'(k), 32'hA5A5_0000 | 32'(k));
            @(negedge clk);
            idle_cycles(6);
        end

        // Write latency and busy window.
        set_req(MEM_WRITE, 10'h005, 32'hDEADBEEF);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            strobe = 1'b0;
            check("wr_ready_t", 0, 32'(ready[0]), 32'(k == 3));
            check("wr_busy_t", 0, 32'(busy[0]), 32'(k <= 3));
            if (k == 0) check("wr1_ready_t", 1, 32'(ready[1]), 32'd1);
        end
        idle_cycles(2);

        // Read-back and hold.
        set_req(MEM_READ, 10'h005, 32'd0);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            strobe = 1'b0;
            if (k == 0) check("rd1_dout", 1, dout[1], 32'hDEADBEEF);
            if (k == 3) check("rd_ready_t", 0, 32'(ready[0]), 32'd1);
            if (k == 3) check("rd_dout", 0, dout[0], 32'hDEADBEEF);
            if (k == 13) check("rd_dout_hold", 0, dout[0], 32'hDEADBEEF);
        end
        idle_cycles(2);

        // Strobe during WAIT: ignored by the slow instance, a real request for the fast one.
        set_req(MEM_WRITE, 10'h007, 32'h0BADF00D);
        @(negedge clk);
        strobe = 1'b0;
        @(negedge clk);
        set_req(MEM_WRITE, 10'h005, 32'h11111111);
        @(negedge clk);
        idle_cycles(6);
`ifdef MEM_ERR_CHECK_EN
        check("ign_err", 0, 32'(err[0]), 32'd1);
        check("ign_err", 1, 32'(err[1]), 32'd0);
`endif
        set_req(MEM_READ, 10'h005, 32'd0);
        @(negedge clk);
        idle_cycles(6);
        check("ign_dout", 0, dout[0], 32'hDEADBEEF);
        check("ign_dout", 1, dout[1], 32'h11111111);

        // Reset two cycles into a write.
        set_req(MEM_WRITE, 10'h00A, 32'h12345678);
        @(negedge clk);
        strobe = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("abort_ready", i, 32'(ready[i]), 32'd0);
            check("abort_busy", i, 32'(busy[i]), 32'd0);
            check("abort_dout", i, dout[i], 32'd0);
            check("abort_err", i, 32'(err[i]), 32'd0);
        end
        reset = 1'b0;
        idle_cycles(2);
        set_req(MEM_READ, 10'h00A, 32'd0);
        @(negedge clk);
        idle_cycles(6);
        check("abort_rd", 0, dout[0], 32'hA5A5000A);
        check("abort_rd", 1, dout[1], 32'h12345678);

        // Back-to-back strobes every two cycles on the single-cycle instance.
        pulses = 0;
        for (int j = 0; j < 6; j++) begin
            set_req(MEM_READ, 10'(j), 32'd0);
            @(negedge clk);
            strobe = 1'b0;
            pulses += int'(ready[1]);
            @(negedge clk);
            pulses += int'(ready[1]);
        end
        repeat (3) begin
            @(negedge clk);
            pulses += int'(ready[1]);
        end
        check("b2b_pulses", 1, 32'(pulses), 32'd6);
        check("b2b_dout", 1, dout[1], 32'h11111111);
        idle_cycles(6);

        // Randomised traffic, including held strobes and occasional resets.
        repeat (600) begin
            @(negedge clk);
            reset  = ($urandom_range(0, 79) == 0);
            strobe = ($urandom_range(0, 2) == 0);
            rw     = 1'($urandom_range(0, 1));
            addr   = 10'($urandom_range(0, 15));
            wdata  = $urandom;
        end
        reset = 1'b0;
        idle_cycles(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
